// File: rtl/stage_1_if.sv
// Fetch stage: PC generation, instruction SRAM request and IF->ID handshake with a one-entry stall buffer.
// Optional build macro IF_PERF_CNT_EN adds the perf_fetch_cnt / perf_flush_cnt counters.
module stage_1_if #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        allow_2,
  output logic        valid_1,
  output logic [63:0] stage_1_to_2,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam logic [31:0] PC_BEFORE_RESET = RESET_PC - 32'd4;

  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] ibuf_q, ibuf_d;
  logic        ibuf_v_q, ibuf_v_d;
  logic        allow_1;
  logic [31:0] nextpc;
  logic [31:0] inst_out;

  always_comb begin
    allow_1  = ~valid_q | allow_2 | br_taken;
    nextpc   = br_taken ? br_target : pc_q + 32'd4;
    pc_d     = pc_q;
    valid_d  = valid_q;
    ibuf_d   = ibuf_q;
    ibuf_v_d = ibuf_v_q;
    if (allow_1) begin
      pc_d     = nextpc;
      valid_d  = 1'b1;
      ibuf_v_d = 1'b0;
    end else if (!ibuf_v_q) begin
      // First stall cycle: capture the read data before the SRAM output drifts.
      ibuf_d   = inst_sram_rdata;
      ibuf_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= PC_BEFORE_RESET;
      valid_q  <= 1'b0;
      ibuf_q   <= 32'd0;
      ibuf_v_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      ibuf_q   <= ibuf_d;
      ibuf_v_q <= ibuf_v_d;
    end
  end

  assign inst_out        = ibuf_v_q ? ibuf_q : inst_sram_rdata;
  assign stage_1_to_2    = {inst_out, pc_q};
  // A redirect cancels the sequential instruction currently held in IF.
  assign valid_1         = valid_q & ~br_taken;
  assign inst_sram_en    = allow_1 & ~reset;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_wdata = 32'b0;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, valid_1 & allow_2};
    flush_cnt_d = flush_cnt_q + {31'd0, valid_q & br_taken};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_stage_1_if.sv
// Bench for stage_1_if: directed scenarios with literal expectations, then randomized traffic against a behavioural fetch model.
module tb_stage_1_if;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        allow_2 = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        valid_1;
  logic [63:0] stage_1_to_2;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'd0;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  stage_1_if #(.RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .reset(reset),
    .allow_2(allow_2),
    .valid_1(valid_1),
    .stage_1_to_2(stage_1_to_2),
    .br_taken(br_taken),
    .br_target(br_target),
    .inst_sram_en(inst_sram_en),
    .inst_sram_we(inst_sram_we),
    .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Program image: one fixed word at 0x1c000008, a scrambled address everywhere else.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h1c000008) return 32'h02800421;
    return (a * 32'h9E3779B1) ^ 32'h13579bdf;
  endfunction

  // SRAM: one-cycle read latency; without a request its output is arbitrary.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem(inst_sram_addr);
    else              inst_sram_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: which PC IF holds, whether it holds anything, and handshake counts.
  logic [31:0] m_pc = RESET_PC - 32'd4;
  bit          m_live = 1'b0;
  bit          started = 1'b0;
  logic [31:0] m_fetch = 32'd0;
  logic [31:0] m_flush = 32'd0;

  always @(posedge clk) begin
    if (reset) begin
      m_live  = 1'b0;
      m_pc    = RESET_PC - 32'd4;
      m_fetch = 32'd0;
      m_flush = 32'd0;
    end else begin
      if (m_live && !br_taken && allow_2) m_fetch = m_fetch + 32'd1;
      if (m_live && br_taken) m_flush = m_flush + 32'd1;
      if (br_taken) begin
        m_pc   = br_target;
        m_live = 1'b1;
      end else if (!m_live || allow_2) begin
        m_pc   = m_pc + 32'd4;
        m_live = 1'b1;
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      bit exp_valid;
      bit exp_en;
      logic [31:0] exp_addr;
      exp_valid = m_live && !br_taken;
      exp_en    = !reset && !(exp_valid && !allow_2);
      exp_addr  = br_taken ? br_target : m_pc + 32'd4;
      chk("m_valid", {63'd0, valid_1}, {63'd0, exp_valid});
      chk("m_en", {63'd0, inst_sram_en}, {63'd0, exp_en});
      chk("m_addr", {32'd0, inst_sram_addr}, {32'd0, exp_addr});
      chk("m_pc", {32'd0, stage_1_to_2[31:0]}, {32'd0, m_pc});
      chk("m_tied", {28'd0, inst_sram_we, inst_sram_wdata}, 64'd0);
      if (exp_valid) chk("m_inst", {32'd0, stage_1_to_2[63:32]}, {32'd0, mem(m_pc)});
`ifdef IF_PERF_CNT_EN
      chk("m_fetch_cnt", {32'd0, perf_fetch_cnt}, {32'd0, m_fetch});
      chk("m_flush_cnt", {32'd0, perf_flush_cnt}, {32'd0, m_flush});
`endif
    end
  end

  // Drive one cycle's inputs just after the rising edge, return just after the falling edge.
  task automatic cyc(input logic rst, input logic a2, input logic br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    reset     = rst;
    allow_2   = a2;
    br_taken  = br;
    br_target = tgt;
    @(negedge clk);
    #1;
  endtask

  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);

    cyc(0, 1, 0, 0);
    chk("t1_en", {63'd0, inst_sram_en}, 64'd1);
    chk("t1_addr0", {32'd0, inst_sram_addr}, 64'h1c000000);
    chk("t1_valid0", {63'd0, valid_1}, 64'd0);
    cyc(0, 1, 0, 0);
    chk("t1_valid1", {63'd0, valid_1}, 64'd1);
    chk("t1_stage", stage_1_to_2, {mem(32'h1c000000), 32'h1c000000});
    chk("t2_addr1", {32'd0, inst_sram_addr}, 64'h1c000004);
    cyc(0, 1, 0, 0);
    chk("t2_addr2", {32'd0, inst_sram_addr}, 64'h1c000008);

    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      chk("t3_en", {63'd0, inst_sram_en}, 64'd0);
      chk("t3_stage", stage_1_to_2, 64'h02800421_1c000008);
      chk("t3_valid", {63'd0, valid_1}, 64'd1);
    end
    cyc(0, 1, 0, 0);
    chk("t3_rel_addr", {32'd0, inst_sram_addr}, 64'h1c00000c);
    chk("t3_rel_stage", stage_1_to_2, 64'h02800421_1c000008);

    cyc(0, 1, 1, 32'h1c000100);
    chk("t4_valid", {63'd0, valid_1}, 64'd0);
    chk("t4_addr", {32'd0, inst_sram_addr}, 64'h1c000100);
    cyc(0, 1, 0, 0);
    chk("t4_pc", {32'd0, stage_1_to_2[31:0]}, 64'h1c000100);
    chk("t4_valid1", {63'd0, valid_1}, 64'd1);
`ifdef IF_PERF_CNT_EN
    chk("t6_fetch_cnt", {32'd0, perf_fetch_cnt}, 64'd3);
    chk("t6_flush_cnt", {32'd0, perf_flush_cnt}, 64'd1);
`endif

    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h1c000200);
    chk("t5_addr", {32'd0, inst_sram_addr}, 64'h1c000200);
    chk("t5_en", {63'd0, inst_sram_en}, 64'd1);
    cyc(0, 0, 0, 0);
    chk("t5_stage", stage_1_to_2, {mem(32'h1c000200), 32'h1c000200});
    chk("t5_valid", {63'd0, valid_1}, 64'd1);
    cyc(0, 0, 0, 0);
    chk("t5_hold", stage_1_to_2, {mem(32'h1c000200), 32'h1c000200});

    cyc(0, 1, 1, 32'hfffffffc);
    chk("t6_addr_top", {32'd0, inst_sram_addr}, 64'hfffffffc);
    cyc(0, 1, 0, 0);
    chk("t6_pc_top", {32'd0, stage_1_to_2[31:0]}, 64'hfffffffc);
    chk("t6_wrap", {32'd0, inst_sram_addr}, 64'h00000000);

    cyc(1, 1, 0, 0);
    chk("rst_en", {63'd0, inst_sram_en}, 64'd0);
    cyc(0, 1, 0, 0);
    chk("rst_pc", {32'd0, stage_1_to_2[31:0]}, 64'h1bfffffc);
    chk("rst_valid", {63'd0, valid_1}, 64'd0);
    chk("rst_addr", {32'd0, inst_sram_addr}, 64'h1c000000);

    for (int i = 0; i < 3000; i++) begin
      logic        r;
      logic        a;
      logic        b;
      logic [31:0] t;
      r = ($urandom_range(0, 99) == 0);
      a = ($urandom_range(0, 9) < 6);
      b = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 15) == 0) ? 32'hfffffffc
                                        : RESET_PC + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      cyc(r, a, b, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
